axi_lite_xbar: RTL



---
 rtl/axi_lite_xbar.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_xbar.sv
// AXI4-Lite 1-to-2 crossbar: LSU master to SRAM (slave 0) and UART (slave 1).
// Each request is latched, decoded against two address windows and replayed; misses get DECERR.
module axi_lite_xbar #(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE  = 32'h0800_0000,
    parameter logic [31:0] UART_BASE = 32'ha000_03f8,
    parameter logic [31:0] UART_SIZE = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rvalid,
    input  logic        m_rready,
    input  logic [31:0] m_awaddr,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    input  logic        m_wvalid,
    output logic        m_wready,
    output logic [1:0]  m_bresp,
    output logic        m_bvalid,
    input  logic        m_bready,
    output logic [31:0] s0_araddr,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    output logic [31:0] s0_awaddr,
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    input  logic [1:0]  s0_bresp,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    output logic [31:0] s1_araddr,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    output logic [31:0] s1_awaddr,
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    input  logic [1:0]  s1_bresp,
    input  logic        s1_bvalid,
    output logic        s1_bready
);

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP, R_ERR} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_ERR} w_state_t;

    // Window limits in 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] MEM_LO  = {1'b0, MEM_BASE};
    localparam logic [32:0] MEM_HI  = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    localparam logic [32:0] UART_LO = {1'b0, UART_BASE};
    localparam logic [32:0] UART_HI = {1'b0, UART_BASE} + {1'b0, UART_SIZE};

    // Returns {hit, target}; target 1 = UART, which wins on overlap.
    function automatic logic [1:0] decode(input logic [31:0] addr);
        logic [32:0] a;
        a = {1'b0, addr};
        if (a >= UART_LO && a < UART_HI)     decode = 2'b11;
        else if (a >= MEM_LO && a < MEM_HI)  decode = 2'b10;
        else                                 decode = 2'b00;
    endfunction

    r_state_t    r_state, r_next;
    logic [31:0] r_addr;
    logic        r_sel;
    logic [1:0]  r_dec;

    assign r_dec = decode(m_araddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && m_arvalid) begin
                r_addr <= m_araddr;
                r_sel  <= r_dec[0];
            end
        end
    end

    always_comb begin
        r_next     = r_state;
        m_arready  = 1'b0;
        m_rdata    = '0;
        m_rresp    = '0;
        m_rvalid   = 1'b0;
        s0_arvalid = 1'b0;
        s0_araddr  = '0;
        s0_rready  = 1'b0;
        s1_arvalid = 1'b0;
        s1_araddr  = '0;
        s1_rready  = 1'b0;
        case (r_state)
            R_IDLE: begin
                m_arready = 1'b1;
                if (m_arvalid) r_next = r_dec[1] ? R_REQ : R_ERR;
            end
            R_REQ: begin
                if (r_sel) begin
                    s1_arvalid = 1'b1;
                    s1_araddr  = r_addr;
                    if (s1_arready) r_next = R_RESP;
                end else begin
                    s0_arvalid = 1'b1;
                    s0_araddr  = r_addr;
                    if (s0_arready) r_next = R_RESP;
                end
            end
            R_RESP: begin
                if (r_sel) begin
                    m_rdata   = s1_rdata;
                    m_rresp   = s1_rresp;
                    m_rvalid  = s1_rvalid;
                    s1_rready = m_rready;
                    if (s1_rvalid && m_rready) r_next = R_IDLE;
                end else begin
                    m_rdata   = s0_rdata;
                    m_rresp   = s0_rresp;
                    m_rvalid  = s0_rvalid;
                    s0_rready = m_rready;
                    if (s0_rvalid && m_rready) r_next = R_IDLE;
                end
            end
            R_ERR: begin
                m_rvalid = 1'b1;
                m_rresp  = 2'b11;
                if (m_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
        if (rst) begin
            m_arready  = 1'b0;
            m_rdata    = '0;
            m_rresp    = '0;
            m_rvalid   = 1'b0;
            s0_arvalid = 1'b0;
            s0_araddr  = '0;
            s0_rready  = 1'b0;
            s1_arvalid = 1'b0;
            s1_araddr  = '0;
            s1_rready  = 1'b0;
        end
    end

    w_state_t    w_state, w_next;
    logic        aw_held, w_held, aw_done, w_done, w_sel;
    logic [31:0] aw_addr, w_data;
    logic [3:0]  w_strb;
    logic        aw_have, w_have, w_go;
    logic [1:0]  w_dec;
    logic        sel_awready, sel_wready;

    // Decode in the cycle the second of AW/W arrives so the slave sees valid one cycle later.
    assign aw_have     = aw_held || m_awvalid;
    assign w_have      = w_held || m_wvalid;
    assign w_go        = (w_state == W_IDLE) && aw_have && w_have;
    assign w_dec       = decode(aw_held ? aw_addr : m_awaddr);
    assign sel_awready = w_sel ? s1_awready : s0_awready;
    assign sel_wready  = w_sel ? s1_wready  : s0_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_sel   <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: begin
                    if (m_awvalid && !aw_held) begin
                        aw_addr <= m_awaddr;
                        aw_held <= 1'b1;
                    end
                    if (m_wvalid && !w_held) begin
                        w_data <= m_wdata;
                        w_strb <= m_wstrb;
                        w_held <= 1'b1;
                    end
                    if (w_go) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        w_sel   <= w_dec[0];
                    end
                end
                W_REQ: begin
                    if (sel_awready) aw_done <= 1'b1;
                    if (sel_wready)  w_done  <= 1'b1;
                    if (w_next != W_REQ) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = w_state;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bresp    = '0;
        m_bvalid   = 1'b0;
        s0_awvalid = 1'b0;
        s0_awaddr  = '0;
        s0_wvalid  = 1'b0;
        s0_wdata   = '0;
        s0_wstrb   = '0;
        s0_bready  = 1'b0;
        s1_awvalid = 1'b0;
        s1_awaddr  = '0;
        s1_wvalid  = 1'b0;
        s1_wdata   = '0;
        s1_wstrb   = '0;
        s1_bready  = 1'b0;
        case (w_state)
            W_IDLE: begin
                m_awready = !aw_held;
                m_wready  = !w_held;
                if (w_go) w_next = w_dec[1] ? W_REQ : W_ERR;
            end
            W_REQ: begin
                if (w_sel) begin
                    s1_awvalid = !aw_done;
                    s1_awaddr  = aw_addr;
                    s1_wvalid  = !w_done;
                    s1_wdata   = w_data;
                    s1_wstrb   = w_strb;
                end else begin
                    s0_awvalid = !aw_done;
                    s0_awaddr  = aw_addr;
                    s0_wvalid  = !w_done;
                    s0_wdata   = w_data;
                    s0_wstrb   = w_strb;
                end
                if ((aw_done || sel_awready) && (w_done || sel_wready)) w_next = W_RESP;
            end
            W_RESP: begin
                if (w_sel) begin
                    m_bresp   = s1_bresp;
                    m_bvalid  = s1_bvalid;
                    s1_bready = m_bready;
                    if (s1_bvalid && m_bready) w_next = W_IDLE;
                end else begin
                    m_bresp   = s0_bresp;
                    m_bvalid  = s0_bvalid;
                    s0_bready = m_bready;
                    if (s0_bvalid && m_bready) w_next = W_IDLE;
                end
            end
            W_ERR: begin
                m_bvalid = 1'b1;
                m_bresp  = 2'b11;
                if (m_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        if (rst) begin
            m_awready  = 1'b0;
            m_wready   = 1'b0;
            m_bresp    = '0;
            m_bvalid   = 1'b0;
            s0_awvalid = 1'b0;
            s0_awaddr  = '0;
            s0_wvalid  = 1'b0;
            s0_wdata   = '0;
            s0_wstrb   = '0;
            s0_bready  = 1'b0;
            s1_awvalid = 1'b0;
            s1_awaddr  = '0;
            s1_wvalid  = 1'b0;
            s1_wdata   = '0;
            s1_wstrb   = '0;
            s1_bready  = 1'b0;
        end
    end

endmodule
